cp0_except_unit: RTL and testbench
==================================

Name: cp0_except_unit

Overview:
- Sits in the MEM stage and owns the CP0 register file.
- Collects raw per-instruction exception flags and external interrupt lines, and prioritises them into the single coded exception word that the pipeline controller consumes.
- Also supplies the EPC value that the controller uses as the ERET target.
- Commits exception state (Status.EXL, Cause, EPC, BadVAddr) and services MFC0/MTC0.

Parameters:
- RESET_STATUS, 32'h0040_0000, Status reset value (BEV=1)
- COUNT_DIV, 1, Count increments every 2^COUNT_DIV cycles

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- we_i  in  1  MTC0 write enable (MEM stage)
- waddr_i  in  5  MTC0 register number
- wdata_i  in  32  MTC0 data
- raddr_i  in  5  MFC0 register number
- rdata_o  out  32  MFC0 read data
- int_i  in  6  external hardware interrupts, level-sensitive
- excflags_i  in  32  raw flags: [8] syscall, [9] RI, [11] Ov, [12] eret, [13] break, [14] AdEL-fetch, [15] AdEL-load, [16] AdES
- inst_addr_i  in  32  PC of MEM-stage instruction; 0 means bubble
- in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- bad_addr_i  in  32  faulting data address (load/store)
- excepttype_o  out  32  coded exception to controller
- cp0_epc_o  out  32  EPC, forwarded
- timer_int_o  out  1  Cause.TI

Behaviour:
- Reset is synchronous and active-high.
  - Registers on reset: Status=RESET_STATUS; Cause, EPC, Count, Compare, BadVAddr = 0; internal divider = 0.
  - Outputs on reset: excepttype_o = 0, rdata_o = 0, cp0_epc_o = 0, timer_int_o = 0.
- Implemented registers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status (writable bits: IM[15:8], EXL[1], IE[0]), 13 Cause (writable bits: IP[9:8] only), 14 EPC.
  - Reads of unimplemented registers return 0.
  - Writes to unimplemented registers are ignored.
- Count increments by 1 every 2^COUNT_DIV cycles and wraps at 32'hFFFF_FFFF → 0.
  - An MTC0 to Count loads the written value and clears the divider.
- Cause.TI is set on the cycle Count == Compare and Compare != 0. It is cleared only by an MTC0 to Compare.
- Cause.IP[15:10] is sampled every cycle as {int_i[5] | TI, int_i[4:0]}.
- Interrupt pending = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM) & (inst_addr_i != 0).
- excepttype_o is combinational, with priority highest first:
  - interrupt → 0x1
  - AdEL-fetch → 0x4
  - RI → 0xa
  - break → 0x9
  - syscall → 0x8
  - Ov → 0xc
  - eret → 0xe
  - AdEL-load → 0x4
  - AdES → 0x5
  - none → 0
- excepttype_o is forced to 0 when inst_addr_i == 0.
- Commit happens at the next clock edge when excepttype_o ∉ {0, 0xe}:
  - If EXL was 0: EPC = in_delayslot_i ? inst_addr_i-4 : inst_addr_i, and Cause.BD = in_delayslot_i. If EXL was already 1, EPC and BD are unchanged.
  - EXL = 1.
  - Cause.ExcCode is set from the code: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
  - For AdEL-fetch: BadVAddr = inst_addr_i. For AdEL-load and AdES: BadVAddr = bad_addr_i.
- eret (0xe): EXL = 0 at the next edge.
- An MTC0 in the same cycle as a nonzero excepttype_o is discarded.
- Forwarding:
  - rdata_o returns wdata_i when we_i and waddr_i == raddr_i.
  - cp0_epc_o returns wdata_i when we_i and waddr_i == 14. Otherwise it returns the registered EPC.
  - Reads of Status and Cause through forwarding apply the write masks.
- Simultaneous TI set and MTC0 Compare: the clear wins.

Test Plan:
- Reset check: assert rst 2 cycles → Status=0x0040_0000, all other registers 0, excepttype_o=0.
- Syscall commit: excflags_i[8]=1, inst_addr_i=0xbfc0_0100, in_delayslot_i=0 → excepttype_o=0x8 same cycle; next cycle EPC=0xbfc0_0100, Cause.ExcCode=8, EXL=1.
- Delay-slot AdES with priority: excflags_i[16]=1 and excflags_i[11]=1, in_delayslot_i=1, inst_addr_i=0x8000_0010, bad_addr_i=0x1001 → excepttype_o=0xc (Ov wins); repeat with only [16] → 0x5, EPC=0x8000_000c, BD=1, BadVAddr unchanged for the Ov case and =0x1001 for the AdES case.
- Timer interrupt:
  - Setup: MTC0 Compare=4, Status=0x0000_8001, inst_addr_i nonzero.
  - When Count reaches 4 → TI=1 and excepttype_o=0x1.
  - MTC0 Compare → TI=0.
- ERET with forwarded EPC: MTC0 EPC=0x1234_5678 and excflags_i[12]=1 in the same cycle → cp0_epc_o=0x1234_5678, excepttype_o=0xe, MTC0 discarded; next cycle EXL=0 and EPC holds the old value.
- Bubble and nested exception:
  - inst_addr_i=0 with excflags_i[9]=1 → excepttype_o=0.
  - With EXL=1, an RI commit leaves EPC unchanged and sets ExcCode=10.

Source files
------------

// File: rtl/cp0_except_unit.sv
// cp0_except_unit: MEM-stage CP0 register file with exception prioritisation,
// exception commit, Count/Compare timer and MFC0/MTC0 forwarding.
module cp0_except_unit #(
    parameter logic [31:0] RESET_STATUS = 32'h0040_0000,
    parameter int          COUNT_DIV    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] excflags_i,
    input  logic [31:0] inst_addr_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cp0_epc_o,
    output logic        timer_int_o
);
    localparam logic [31:0] STATUS_WM = 32'h0000_ff03;
    localparam logic [31:0] CAUSE_WM  = 32'h0000_0300;
    localparam logic [7:0]  DIV_MAX   = 8'((1 << COUNT_DIV) - 1);
    localparam logic [4:0]  R_BADV    = 5'd8;
    localparam logic [4:0]  R_COUNT   = 5'd9;
    localparam logic [4:0]  R_COMPARE = 5'd11;
    localparam logic [4:0]  R_STATUS  = 5'd12;
    localparam logic [4:0]  R_CAUSE   = 5'd13;
    localparam logic [4:0]  R_EPC     = 5'd14;

    logic [31:0] badv_q, badv_d, count_q, count_d, compare_q, compare_d;
    logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d;
    logic [7:0]  div_q, div_d;
    logic [31:0] status_fwd, cause_fwd, rd_reg;
    logic [4:0]  code;
    logic        int_pend, fetch_err, commit, eret, wr, tick, ti_d, fwd_impl;
    logic        unused_ok;

    assign unused_ok = ^{excflags_i[31:17], excflags_i[10], excflags_i[7:0]};

    always_comb begin
        int_pend     = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8])) & (inst_addr_i != 32'd0);
        code         = int_pend       ? 5'h01 :
                       excflags_i[14] ? 5'h04 :
                       excflags_i[9]  ? 5'h0a :
                       excflags_i[13] ? 5'h09 :
                       excflags_i[8]  ? 5'h08 :
                       excflags_i[11] ? 5'h0c :
                       excflags_i[12] ? 5'h0e :
                       excflags_i[15] ? 5'h04 :
                       excflags_i[16] ? 5'h05 : 5'h00;
        excepttype_o = (inst_addr_i == 32'd0) ? 32'd0 : {27'd0, code};
        fetch_err    = ~int_pend & excflags_i[14];
        commit       = (excepttype_o != 32'd0) && (excepttype_o != 32'h0e);
        eret         = excepttype_o == 32'h0e;
        // Any MTC0 alongside an exception (including eret) is dropped.
        wr           = we_i && (excepttype_o == 32'd0);
        tick         = div_q == DIV_MAX;
        div_d        = ((wr && waddr_i == R_COUNT) || tick) ? 8'd0 : div_q + 8'd1;
        count_d      = (wr && waddr_i == R_COUNT) ? wdata_i : count_q + {31'd0, tick};
        compare_d    = (wr && waddr_i == R_COMPARE) ? wdata_i : compare_q;
        ti_d         = (wr && waddr_i == R_COMPARE) ? 1'b0 :
                       ((count_q == compare_q) && (compare_q != 32'd0)) ? 1'b1 : cause_q[30];
        status_fwd   = (status_q & ~STATUS_WM) | (wdata_i & STATUS_WM);
        cause_fwd    = (cause_q & ~CAUSE_WM) | (wdata_i & CAUSE_WM);
        status_d     = (wr && waddr_i == R_STATUS) ? status_fwd : status_q;
        status_d[1]  = commit ? 1'b1 : eret ? 1'b0 : status_d[1];
        cause_d         = (wr && waddr_i == R_CAUSE) ? cause_fwd : cause_q;
        cause_d[30]     = ti_d;
        cause_d[15:10]  = {int_i[5] | ti_d, int_i[4:0]};
        if (commit) begin
            cause_d[6:2] = (code == 5'h01) ? 5'd0 : code;
            cause_d[31]  = status_q[1] ? cause_q[31] : in_delayslot_i;
        end
        epc_d        = (commit && !status_q[1]) ? (in_delayslot_i ? inst_addr_i - 32'd4 : inst_addr_i) :
                       (wr && waddr_i == R_EPC) ? wdata_i : epc_q;
        badv_d       = (commit && fetch_err) ? inst_addr_i :
                       (commit && (code == 5'h04 || code == 5'h05)) ? bad_addr_i :
                       (wr && waddr_i == R_BADV) ? wdata_i : badv_q;
        rd_reg       = (raddr_i == R_BADV)    ? badv_q :
                       (raddr_i == R_COUNT)   ? count_q :
                       (raddr_i == R_COMPARE) ? compare_q :
                       (raddr_i == R_STATUS)  ? status_q :
                       (raddr_i == R_CAUSE)   ? cause_q :
                       (raddr_i == R_EPC)     ? epc_q : 32'd0;
        fwd_impl     = (raddr_i == R_BADV) || (raddr_i == R_COUNT) || (raddr_i == R_COMPARE) || (raddr_i == R_EPC);
        rdata_o      = !(we_i && waddr_i == raddr_i) ? rd_reg :
                       (raddr_i == R_STATUS) ? status_fwd :
                       (raddr_i == R_CAUSE)  ? cause_fwd :
                       fwd_impl ? wdata_i : 32'd0;
        cp0_epc_o    = (we_i && waddr_i == R_EPC) ? wdata_i : epc_q;
        timer_int_o  = cause_q[30];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            badv_q    <= 32'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            status_q  <= RESET_STATUS;
            cause_q   <= 32'd0;
            epc_q     <= 32'd0;
            div_q     <= 8'd0;
        end else begin
            badv_q    <= badv_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            div_q     <= div_d;
        end
    end
endmodule

// File: tb/tb_cp0_except_unit.sv
// tb_cp0_except_unit: directed stimulus with a field-level CP0 model checked
// against the DUT every cycle, plus literal expectations at key points.
module tb_cp0_except_unit;
    localparam logic [31:0] RST_STATUS = 32'h0040_0000;
    localparam int          CD         = 1;

    logic        clk = 1'b0, rst, we, ds, started = 1'b0;
    logic [4:0]  waddr, raddr;
    logic [31:0] wdata, flags, inst, bad;
    logic [5:0]  irq;
    logic [31:0] rdata_o, excepttype_o, cp0_epc_o;
    logic        timer_int_o;
    int          n_cmp = 0, n_bad = 0;

    cp0_except_unit #(.RESET_STATUS(RST_STATUS), .COUNT_DIV(CD)) dut (
        .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(rdata_o), .int_i(irq), .excflags_i(flags),
        .inst_addr_i(inst), .in_delayslot_i(ds), .bad_addr_i(bad),
        .excepttype_o(excepttype_o), .cp0_epc_o(cp0_epc_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    // Architectural model kept as named fields rather than packed registers.
    logic [31:0] m_badv, m_count, m_compare, m_epc;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [7:0]  m_im, m_ip;
    logic [4:0]  m_exc;
    int          m_cyc;
    int          pri_bit[8]  = '{14, 9, 13, 8, 11, 12, 15, 16};
    int          pri_code[8] = '{4, 10, 9, 8, 12, 14, 4, 5};

    function automatic logic [31:0] exp_type();
        if (inst == 32'd0) return 32'd0;
        if (m_ie && !m_exl && ((m_ip & m_im) != 8'd0)) return 32'd1;
        for (int i = 0; i < 8; i++) if (flags[pri_bit[i]]) return 32'(pri_code[i]);
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_status();
        return (RST_STATUS & ~32'h0000_ff03) | {16'd0, m_im, 6'd0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'd0, m_ip, 1'b0, m_exc, 2'b00};
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (we && waddr == raddr) begin
            if (raddr == 5'd12) return (RST_STATUS & ~32'h0000_ff03) | (wdata & 32'h0000_ff03);
            if (raddr == 5'd13) return {m_bd, m_ti, 14'd0, m_ip[7:2], wdata[9:8], 1'b0, m_exc, 2'b00};
            if (raddr == 5'd8 || raddr == 5'd9 || raddr == 5'd11 || raddr == 5'd14) return wdata;
            return 32'd0;
        end
        case (raddr)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] t;
        logic        acc, hit;
        if (rst) begin
            {m_badv, m_count, m_compare, m_epc} = '0;
            {m_exl, m_ie, m_bd, m_ti, m_im, m_ip, m_exc} = '0;
            m_cyc = 0;
            return;
        end
        t   = exp_type();
        acc = we && (t == 32'd0);
        hit = (m_count == m_compare) && (m_compare != 32'd0);
        if (acc && waddr == 5'd9) begin
            m_count = wdata;
            m_cyc   = 0;
        end else begin
            m_cyc++;
            if (m_cyc == (1 << CD)) begin
                m_cyc = 0;
                m_count++;
            end
        end
        if (acc && waddr == 5'd11) begin
            m_compare = wdata;
            m_ti      = 1'b0;
        end else if (hit) m_ti = 1'b1;
        if (acc && waddr == 5'd12) {m_im, m_exl, m_ie} = {wdata[15:8], wdata[1], wdata[0]};
        if (acc && waddr == 5'd13) m_ip[1:0] = wdata[9:8];
        if (acc && waddr == 5'd8) m_badv = wdata;
        if (acc && waddr == 5'd14) m_epc = wdata;
        m_ip[7:2] = {irq[5] | m_ti, irq[4:0]};
        if (t == 32'd14) m_exl = 1'b0;
        else if (t != 32'd0) begin
            if (!m_exl) begin
                m_epc = ds ? inst - 32'd4 : inst;
                m_bd  = ds;
            end
            m_exl = 1'b1;
            m_exc = (t == 32'd1) ? 5'd0 : t[4:0];
            if (t == 32'd4 && flags[14]) m_badv = inst;
            else if (t == 32'd4 || t == 32'd5) m_badv = bad;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (started) begin
        chk("type", excepttype_o, exp_type());
        chk("rdata", rdata_o, exp_rdata());
        chk("epc_fwd", cp0_epc_o, (we && waddr == 5'd14) ? wdata : m_epc);
        chk("timer", {31'd0, timer_int_o}, {31'd0, m_ti});
    end

    task automatic idle();
        we = 0; waddr = 0; wdata = 0; raddr = 0; irq = 0;
        flags = 0; inst = 0; ds = 0; bad = 0;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        go(); idle(); we = 1; waddr = a; wdata = d;
    endtask

    initial begin
        idle();
        rst = 1;
        go(); started = 1; raddr = 12;
        @(negedge clk); chk("rst_status", rdata_o, 32'h0040_0000);
        go(); rst = 0; raddr = 13;
        @(negedge clk);
        chk("rst_cause", rdata_o, 32'd0);
        chk("rst_epc", cp0_epc_o, 32'd0);
        chk("rst_type", excepttype_o, 32'd0);
        chk("rst_ti", {31'd0, timer_int_o}, 32'd0);
        // syscall commit
        go(); idle(); inst = 32'hbfc0_0100; flags = 32'h100;
        @(negedge clk); chk("sys_type", excepttype_o, 32'h8);
        go(); idle(); raddr = 14; @(negedge clk); chk("sys_epc", rdata_o, 32'hbfc0_0100);
        go(); raddr = 13; @(negedge clk); chk("sys_cause", rdata_o, 32'h0000_0020);
        go(); raddr = 12; @(negedge clk); chk("sys_status", rdata_o, 32'h0040_0002);
        // eret, then Ov beats AdES in a delay slot
        go(); idle(); inst = 32'h100; flags = 32'h1000;
        @(negedge clk); chk("eret_type", excepttype_o, 32'he);
        go(); idle(); inst = 32'h8000_0010; ds = 1; bad = 32'h1001; flags = 32'h1_0800;
        @(negedge clk); chk("ov_type", excepttype_o, 32'hc);
        go(); idle(); raddr = 8; @(negedge clk); chk("ov_badv", rdata_o, 32'd0);
        go(); raddr = 14; @(negedge clk); chk("ov_epc", rdata_o, 32'h8000_000c);
        go(); idle(); inst = 32'h100; flags = 32'h1000;
        go(); idle(); inst = 32'h8000_0010; ds = 1; bad = 32'h1001; flags = 32'h1_0000;
        @(negedge clk); chk("ades_type", excepttype_o, 32'h5);
        go(); idle(); raddr = 8; @(negedge clk); chk("ades_badv", rdata_o, 32'h1001);
        go(); raddr = 13; @(negedge clk); chk("ades_cause", rdata_o, 32'h8000_0014);
        go(); raddr = 14; @(negedge clk); chk("ades_epc", rdata_o, 32'h8000_000c);
        // bubble, then nested RI with EXL set
        go(); idle(); flags = 32'h200; @(negedge clk); chk("bubble_type", excepttype_o, 32'd0);
        go(); idle(); inst = 32'h400; flags = 32'h200; @(negedge clk); chk("ri_type", excepttype_o, 32'ha);
        go(); idle(); raddr = 14; @(negedge clk); chk("ri_epc", rdata_o, 32'h8000_000c);
        go(); raddr = 13; @(negedge clk); chk("ri_cause", rdata_o, 32'h8000_0028);
        // eret alongside an EPC write: forwarded but not committed
        go(); idle(); inst = 32'h500; flags = 32'h1000; we = 1; waddr = 14; wdata = 32'h1234_5678;
        @(negedge clk);
        chk("eret_fwd", cp0_epc_o, 32'h1234_5678);
        chk("eret_fwd_type", excepttype_o, 32'he);
        go(); idle(); raddr = 12; @(negedge clk); chk("eret_status", rdata_o, 32'h0040_0000);
        go(); raddr = 14; @(negedge clk); chk("eret_epc", rdata_o, 32'h8000_000c);
        // timer interrupt
        mtc0(5'd11, 32'd4);
        mtc0(5'd9, 32'd0);
        mtc0(5'd12, 32'h0000_8001);
        go(); idle(); raddr = 9;
        for (int i = 0; i < 40 && !timer_int_o; i++) go();
        @(negedge clk); chk("ti_set", {31'd0, timer_int_o}, 32'd1);
        go(); idle(); inst = 32'h600; @(negedge clk); chk("int_type", excepttype_o, 32'h1);
        go(); idle(); raddr = 13; @(negedge clk); chk("int_cause", rdata_o, 32'h4000_8000);
        go(); raddr = 14; @(negedge clk); chk("int_epc", rdata_o, 32'h600);
        mtc0(5'd11, 32'h100);
        go(); idle(); raddr = 13;
        @(negedge clk);
        chk("ti_clr", {31'd0, timer_int_o}, 32'd0);
        chk("ti_clr_cause", rdata_o, 32'd0);
        repeat (4) go();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
